// File: rtl/ssd_host_arbiter.sv
// Round-robin arbiter sharing one single-port SSD between N_REQ host requesters.
// One command in flight at a time; reads re-strobe the same address RD_STROBES times.
module ssd_host_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RD_STROBES = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  output logic [N_REQ-1:0]      req_grant,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [31:0]           ssd_addr,
  output logic [31:0]           ssd_data_in,
  output logic                  ssd_read_enable,
  output logic                  ssd_write_enable,
  input  logic [31:0]           ssd_data_out,
  input  logic                  ssd_ready
);
  localparam int PW = $clog2(N_REQ);
  localparam int SW = $clog2(RD_STROBES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d, sel_q, sel_d, pick;
  logic             wr_q, wr_d, found;
  logic [SW-1:0]    strb_cnt_q, strb_cnt_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [N_REQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic             re_q, re_d, we_q, we_d;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    wr_d        = wr_q;
    strb_cnt_d  = strb_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    re_d        = 1'b0;
    we_d        = 1'b0;
    found       = 1'b0;
    pick        = '0;
    // First valid requester at or after rr_ptr, scanning cyclically.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[PW'((int'(rr_ptr_q) + i) % N_REQ)]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_ptr_q) + i) % N_REQ);
      end
    end
    case (state_q)
      IDLE: if (found) begin
        state_d       = ISSUE;
        sel_d         = pick;
        wr_d          = req_write[pick];
        addr_d        = req_addr[32*pick +: 32];
        wdata_d       = req_wdata[32*pick +: 32];
        rr_ptr_d      = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        strb_cnt_d    = SW'(1);
        grant_d[pick] = 1'b1;
        we_d          = req_write[pick];
        re_d          = ~req_write[pick];
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        if (ssd_ready) begin
          if (!wr_q && strb_cnt_q != SW'(RD_STROBES)) begin
            state_d    = ISSUE;
            strb_cnt_d = strb_cnt_q + 1'b1;
            re_d       = 1'b1;
          end else begin
            state_d            = RESP;
            rsp_valid_d[sel_q] = 1'b1;
            rsp_rdata_d        = wr_q ? 32'h0 : ssd_data_out;
          end
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          state_d            = RESP;
          rsp_valid_d[sel_q] = 1'b1;
          rsp_err_d          = 1'b1;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      wr_q        <= 1'b0;
      strb_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      wr_q        <= wr_d;
      strb_cnt_q  <= strb_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      re_q        <= re_d;
      we_q        <= we_d;
    end
  end

  assign req_grant        = grant_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign busy             = busy_q;
  assign ssd_addr         = addr_q;
  assign ssd_data_in      = wdata_q;
  assign ssd_read_enable  = re_q;
  assign ssd_write_enable = we_q;
endmodule

// File: tb/tb_ssd_host_arbiter.sv
// Directed bench for ssd_host_arbiter: vector table, round-robin, timeout, reset and mixed traffic,
// against a two-stage SSD read-path model that can be told never to answer.
module tb_ssd_host_arbiter;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid, req_write, req_grant, rsp_valid;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  rsp_rdata, ssd_addr, ssd_data_in, ssd_data_out;
  logic         rsp_err, busy, ssd_read_enable, ssd_write_enable, ssd_ready;
  bit           hang = 1'b0;
  int           total = 0, passed = 0, both_hi = 0;

  ssd_host_arbiter #(.N_REQ(4), .RD_STROBES(2), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .ssd_addr(ssd_addr),
    .ssd_data_in(ssd_data_in), .ssd_read_enable(ssd_read_enable),
    .ssd_write_enable(ssd_write_enable), .ssd_data_out(ssd_data_out), .ssd_ready(ssd_ready));

  always #5 clk = ~clk;

  // SSD model: one-cycle ready pulse after each strobe, read data two registers deep.
  logic [31:0] mem [256];
  logic [31:0] stage1;
  always @(posedge clk) begin
    ssd_ready <= 1'b0;
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5500_0000 + 32'(i);
      stage1       <= '0;
      ssd_data_out <= '0;
    end else begin
      if (ssd_write_enable) begin
        mem[ssd_addr[7:0]] <= ssd_data_in;
        if (!hang) ssd_ready <= 1'b1;
      end
      if (ssd_read_enable) begin
        stage1       <= mem[ssd_addr[7:0]];
        ssd_data_out <= stage1;
        if (!hang) ssd_ready <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (ssd_read_enable && ssd_write_enable) both_hi++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  valid, write;
    logic [31:0] addr, wdata;
    bit          hang;
    int          idx, rcyc;
    logic [31:0] rdata;
    logic        err;
    int          nre, nwe;
  } vec_t;

  function automatic vec_t mk(string nm, logic [3:0] v, logic [3:0] w, logic [31:0] a,
                              logic [31:0] d, bit h, int ix, int rc, logic [31:0] rd,
                              logic e, int nr, int nw);
    vec_t t;
    t.name = nm; t.valid = v; t.write = w; t.addr = a; t.wdata = d; t.hang = h;
    t.idx = ix; t.rcyc = rc; t.rdata = rd; t.err = e; t.nre = nr; t.nwe = nw;
    return t;
  endfunction

  function automatic int oh2i(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = v;
    req_write = w;
    for (int i = 0; i < 4; i++) begin
      req_addr[32*i +: 32]  = a;
      req_wdata[32*i +: 32] = d;
    end
  endtask

  // Cycle c counts edges after the request is driven: edge 1 samples it in IDLE.
  task automatic run_vec(input vec_t v);
    logic [3:0]  gv, rv;
    logic [31:0] rd;
    logic        er;
    int          gc, rc, nre, nwe;
    gv = '0; rv = '0; rd = '0; er = 1'b0; gc = -1; rc = -1; nre = 0; nwe = 0;
    hang = v.hang;
    drive(v.valid, v.write, v.addr, v.wdata);
    for (int c = 1; c <= 40 && rc < 0; c++) begin
      @(posedge clk); #1;
      if (|req_grant) begin gv = req_grant; gc = c; req_valid = '0; end
      nre += int'(ssd_read_enable);
      nwe += int'(ssd_write_enable);
      if (|rsp_valid) begin rv = rsp_valid; rc = c; rd = rsp_rdata; er = rsp_err; end
    end
    req_valid = '0;
    @(posedge clk); #1;
    check({v.name, " grant"},    32'(gv), 32'(4'b0001 << v.idx));
    check({v.name, " gcyc"},     32'(gc), 32'd1);
    check({v.name, " rsp"},      32'(rv), 32'(4'b0001 << v.idx));
    check({v.name, " rcyc"},     32'(rc), 32'(v.rcyc));
    check({v.name, " rdata"},    rd, v.rdata);
    check({v.name, " err"},      32'(er), 32'(v.err));
    check({v.name, " strobes"},  32'(nre * 16 + nwe), 32'(v.nre * 16 + v.nwe));
    check({v.name, " idle"},     32'(busy), 32'd0);
  endtask

  vec_t        vt [8];
  int          ord [5];
  int          rspc [4];
  int          exp_ord [5] = '{0, 1, 2, 3, 0};
  int          exp_rspc [4] = '{2, 1, 1, 1};
  logic [31:0] shadow [256];

  initial begin
    // Round-robin pointer after each vector: 1,1,3,1,0,2,3,0.
    vt[0] = mk("wr0",      4'b0001, 4'b0001, 32'h10, 32'hCAFE0001, 0, 0,  3, 32'h0,        0, 0, 1);
    vt[1] = mk("rd0",      4'b0001, 4'b0000, 32'h10, 32'h0,        0, 0,  5, 32'hCAFE0001, 0, 2, 0);
    vt[2] = mk("rd_init",  4'b0100, 4'b0000, 32'h20, 32'h0,        0, 2,  5, 32'h55000020, 0, 2, 0);
    vt[3] = mk("rr_wrap",  4'b0011, 4'b0011, 32'h30, 32'h12345678, 0, 0,  3, 32'h0,        0, 0, 1);
    vt[4] = mk("rr_skip",  4'b1001, 4'b0000, 32'h30, 32'h0,        0, 3,  5, 32'h12345678, 0, 2, 0);
    vt[5] = mk("wr_to",    4'b0010, 4'b0010, 32'h40, 32'hDEAD0040, 1, 1, 17, 32'h0,        1, 0, 1);
    vt[6] = mk("rd_to",    4'b0100, 4'b0000, 32'h10, 32'h0,        1, 2, 17, 32'h0,        1, 1, 0);
    vt[7] = mk("rd_post",  4'b1000, 4'b0000, 32'h10, 32'h0,        0, 3,  5, 32'hCAFE0001, 0, 2, 0);

    reset_n = 1'b0;
    drive(4'b0, 4'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst grant_rsp", 32'({req_grant, rsp_valid}), 32'h0);
    check("rst rdata",     rsp_rdata, 32'h0);
    check("rst ssd_addr",  ssd_addr, 32'h0);
    check("rst ssd_data",  ssd_data_in, 32'h0);
    check("rst flags",     32'({rsp_err, busy, ssd_read_enable, ssd_write_enable}), 32'h0);
    #3 reset_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vt[k]);

    // All four request continuously: expect 0,1,2,3,0.
    for (int i = 0; i < 5; i++) ord[i] = -1;
    for (int i = 0; i < 4; i++) rspc[i] = 0;
    hang = 1'b0;
    drive(4'hF, 4'hF, 32'h60, 32'h0000_6060);
    begin
      int ng, nr;
      ng = 0; nr = 0;
      for (int c = 0; c < 80 && nr < 5; c++) begin
        @(posedge clk); #1;
        if (|req_grant && ng < 5) begin
          ord[ng] = oh2i(req_grant);
          ng++;
          if (ng == 5) req_valid = '0;
        end
        if (|rsp_valid) begin
          nr++;
          for (int i = 0; i < 4; i++) if (rsp_valid[i]) rspc[i]++;
        end
      end
    end
    req_valid = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) check($sformatf("rr order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    for (int i = 0; i < 4; i++) check($sformatf("rr rsp%0d", i), 32'(rspc[i]), 32'(exp_rspc[i]));

    // Reset while a read from requester 1 sits in WAIT.
    hang = 1'b1;
    drive(4'b0010, 4'b0000, 32'h10, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid-rst strobes", 32'({ssd_read_enable, ssd_write_enable}), 32'h0);
    check("mid-rst busy",    32'(busy), 32'd0);
    check("mid-rst rsp",     32'({req_grant, rsp_valid}), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    run_vec(mk("post_rst", 4'b0011, 4'b0000, 32'h10, 32'h0, 0, 0, 5, 32'h55000010, 0, 2, 0));

    // Mixed random traffic against a shadow of SSD contents.
    for (int i = 0; i < 256; i++) shadow[i] = 32'h5500_0000 + 32'(i);
    hang = 1'b0;
    begin
      int nrsp, idx_err, data_err;
      nrsp = 0; idx_err = 0; data_err = 0;
      for (int n = 0; n < 1000; n++) begin
        logic [3:0]  m, g;
        logic        w, done;
        logic [7:0]  a;
        logic [31:0] d;
        m = 4'($urandom_range(1, 15));
        w = 1'($urandom_range(0, 1));
        a = 8'($urandom_range(0, 255));
        d = $urandom;
        g = '0;
        done = 1'b0;
        drive(m, w ? 4'hF : 4'h0, {24'h0, a}, d);
        for (int c = 0; c < 40 && !done; c++) begin
          @(posedge clk); #1;
          if (|req_grant) begin
            if (|g) idx_err++;
            g = req_grant;
            req_valid = '0;
          end
          if (|rsp_valid) begin
            done = 1'b1;
            nrsp++;
            if (rsp_valid !== g) idx_err++;
            if (rsp_err) data_err++;
            if (w) shadow[a] = d;
            else if (rsp_rdata !== shadow[a]) data_err++;
          end
        end
        if (!done) idx_err++;
        req_valid = '0;
      end
      check("rand rsp count",   32'(nrsp), 32'd1000);
      check("rand grant/rsp",   32'(idx_err), 32'd0);
      check("rand data",        32'(data_err), 32'd0);
      check("strobe exclusive", 32'(both_hi), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
